// File: rtl/aes_byte_serial_stub.sv
// aes_byte_serial_stub: behavioural stand-in for the byte-serial AES core.
// Captures 16 plaintext/key bytes after a start strobe, idles for LATENCY
// cycles, then pulses done_o and streams pt^key (MSB first) on ct_o.
// Optional feature: define AES_STUB_CHAIN_EN to XOR each result with the
// previous one (chain_reg), so identical requests alternate their output.
module aes_byte_serial_stub #(
  parameter int LATENCY = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] pt_i,
  input  logic [7:0] key_i,
  output logic       done_o,
  output logic [7:0] ct_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;

  // WAIT counts down from LATENCY-1 so it lasts exactly LATENCY cycles.
  localparam logic [7:0] LAT_INIT = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  state_t       state;
  logic [3:0]   byte_cnt;
  logic [7:0]   lat_cnt;
  logic [127:0] pt_buf;
  logic [127:0] key_buf;
  logic [127:0] pt_nxt;
  logic [127:0] key_nxt;
  logic [127:0] res_nxt;
`ifdef AES_STUB_CHAIN_EN
  logic [127:0] chain_reg;
`endif

  // Byte idx of a 128-bit word, byte 0 being bits [127:120].
  function automatic logic [7:0] byte_sel(input logic [127:0] v, input logic [3:0] idx);
    logic [127:0] sh;
    sh = v << {idx, 3'b000};
    return sh[127:120];
  endfunction

  // Buffer contents as they will be after this edge; lets the first result
  // byte be registered on the same edge that captures the last input byte.
  always_comb begin
    pt_nxt  = pt_buf;
    key_nxt = key_buf;
    if (state == LOAD) begin
      pt_nxt  = {pt_buf[119:0], pt_i};
      key_nxt = {key_buf[119:0], key_i};
    end
`ifdef AES_STUB_CHAIN_EN
    res_nxt = pt_nxt ^ key_nxt ^ chain_reg;
`else
    res_nxt = pt_nxt ^ key_nxt;
`endif
  end

  // Protocol FSM with registered done/ct/busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 4'd0;
      lat_cnt   <= 8'd0;
      pt_buf    <= '0;
      key_buf   <= '0;
`ifdef AES_STUB_CHAIN_EN
      chain_reg <= '0;
`endif
      done_o    <= 1'b0;
      ct_o      <= 8'h00;
      busy_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      ct_o   <= 8'h00;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= LOAD;
            byte_cnt <= 4'd0;
            busy_o   <= 1'b1;
          end
        end
        LOAD: begin
          pt_buf   <= pt_nxt;
          key_buf  <= key_nxt;
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == 4'd15) begin
            lat_cnt  <= LAT_INIT;
            byte_cnt <= 4'd0;
            if (LATENCY > 0) begin
              state <= WAIT;
            end else begin
              state  <= OUT;
              done_o <= 1'b1;
              ct_o   <= byte_sel(res_nxt, 4'd0);
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 8'd0) begin
            state    <= OUT;
            byte_cnt <= 4'd0;
            done_o   <= 1'b1;
            ct_o     <= byte_sel(res_nxt, 4'd0);
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        OUT: begin
          if (byte_cnt == 4'd15) begin
            state    <= IDLE;
            byte_cnt <= 4'd0;
            busy_o   <= 1'b0;
`ifdef AES_STUB_CHAIN_EN
            chain_reg <= res_nxt;
`endif
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
            ct_o     <= byte_sel(res_nxt, byte_cnt + 4'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_serial_stub.sv
// Directed bench for aes_byte_serial_stub: two instances (LATENCY 20 and 0)
// with separate start strobes and shared data inputs. Expected outputs
// follow the cycle offsets from each accepted start.
module tb_aes_byte_serial_stub;

`ifdef AES_STUB_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_w;
  logic [7:0] pt;
  logic [7:0] key;
  logic       done_w [2];
  logic [7:0] ct_w   [2];
  logic       busy_w [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int drv_s  = -1000;

  int s_cyc    [2];
  int lat      [2];
  bit active   [2];
  int done_cnt [2];
  bit par      [2];

  always #5 clk = ~clk;

  aes_byte_serial_stub #(.LATENCY(20)) u_lat20 (
    .clk(clk), .rst(rst), .start_i(start_w[0]), .pt_i(pt), .key_i(key),
    .done_o(done_w[0]), .ct_o(ct_w[0]), .busy_o(busy_w[0])
  );

  aes_byte_serial_stub #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .start_i(start_w[1]), .pt_i(pt), .key_i(key),
    .done_o(done_w[1]), .ct_o(ct_w[1]), .busy_o(busy_w[1])
  );

  // pt byte k = {k,k}, key byte k = {0,k}: result byte k = {k,0}.
  // With chaining, every second completed request yields all zeros.
  function automatic logic [7:0] exp_byte(input int k, input bit odd);
    logic [3:0] n;
    n = k[3:0];
    if (CHAIN_ON && odd) return 8'h00;
    return {n, 4'h0};
  endfunction

  task automatic check_all();
    int c;
    bit eb;
    bit ed;
    logic [7:0] ec;
    for (int i = 0; i < 2; i++) begin
      eb = 1'b0; ed = 1'b0; ec = 8'h00;
      if (active[i]) begin
        c  = cyc - s_cyc[i];
        eb = (c >= 1) && (c <= 32 + lat[i]);
        ed = (c == 17 + lat[i]);
        if (c >= 17 + lat[i] && c <= 32 + lat[i]) ec = exp_byte(c - 17 - lat[i], par[i]);
        if (c == 32 + lat[i]) done_cnt[i]++;
      end
      checks++;
      assert (busy_w[i] === eb) else begin
        errors++;
        $error("FAIL busy lat%0d cyc %0d: observed %0b expected %0b", lat[i], cyc, busy_w[i], eb);
      end
      checks++;
      assert (done_w[i] === ed) else begin
        errors++;
        $error("FAIL done lat%0d cyc %0d: observed %0b expected %0b", lat[i], cyc, done_w[i], ed);
      end
      checks++;
      assert (ct_w[i] === ec) else begin
        errors++;
        $error("FAIL ct lat%0d cyc %0d: observed %02h expected %02h", lat[i], cyc, ct_w[i], ec);
      end
    end
  endtask

  // Advance one cycle, drive that cycle's data byte, check both instances.
  task automatic step();
    int c;
    int k;
    @(posedge clk);
    #1;
    cyc++;
    start_w = 2'b00;
    c = cyc - drv_s;
    if (c >= 1 && c <= 16) begin
      k   = c - 1;
      pt  = {k[3:0], k[3:0]};
      key = {4'h0, k[3:0]};
    end else begin
      pt  = 8'h00;
      key = 8'h00;
    end
    check_all();
  endtask

  // Pulse start on the selected instances; an instance accepts only when idle.
  task automatic issue_start(input bit [1:0] mask, input bit real_req);
    for (int i = 0; i < 2; i++) begin
      if (mask[i]) begin
        start_w[i] = 1'b1;
        if (!active[i] || cyc > s_cyc[i] + 32 + lat[i]) begin
          active[i] = 1'b1;
          s_cyc[i]  = cyc;
          par[i]    = done_cnt[i][0];
        end
      end
    end
    if (real_req) drv_s = cyc;
  endtask

  initial begin
    lat[0] = 20; lat[1] = 0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; s_cyc[i] = 0; done_cnt[i] = 0; par[i] = 1'b0;
    end
    rst = 1'b1; start_w = 2'b00; pt = 8'h00; key = 8'h00;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic request on both latencies
    issue_start(2'b11, 1'b1);
    repeat (60) step();

    // Start strobes while busy, including each instance's last OUT cycle
    issue_start(2'b11, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 5)  issue_start(2'b11, 1'b0);
      if (c == 20) issue_start(2'b11, 1'b0);
      if (c == 25) issue_start(2'b01, 1'b0);
      if (c == 32) issue_start(2'b10, 1'b0);
      if (c == 40) issue_start(2'b01, 1'b0);
      if (c == 52) issue_start(2'b01, 1'b0);
    end

    // Back-to-back on the LATENCY=0 instance
    issue_start(2'b11, 1'b1);
    for (int c = 1; c <= 80; c++) begin
      step();
      if (c == 33) issue_start(2'b10, 1'b1);
    end

    // Back-to-back on the LATENCY=20 instance
    issue_start(2'b11, 1'b1);
    for (int c = 1; c <= 110; c++) begin
      step();
      if (c == 53) issue_start(2'b01, 1'b1);
    end

    // Mid-operation reset in cycle T+10
    issue_start(2'b11, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; done_cnt[i] = 0;
    end
    drv_s = -1000;
    #1;
    check_all();
    step();
    rst = 1'b0;
    step();

    // Two identical requests after reset: chaining makes the second zero
    issue_start(2'b11, 1'b1);
    repeat (60) step();
    issue_start(2'b11, 1'b1);
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
